// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the registered-read ROM and presents
// opcode/operand over valid/ready. Define IFU_PREFETCH_EN to enable next-word prefetch.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       INSTR_W    = 26,
  parameter int unsigned       OPC_W      = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [OPC_W-1:0]  HALT_OPC   = OPC_W'(255)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        instr_addr,
  input  logic [INSTR_W-1:0]       instr_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPC_W-1:0]         opcode,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic [ADDR_W-1:0]        pc,
  input  logic                     jump_req,
  input  logic [ADDR_W-1:0]        jump_target,
  output logic                     halted
);

  typedef enum logic [1:0] {ISSUE, CAPTURE, PRESENT, HALTED} state_t;

  state_t                   state, next_state;
  logic [ADDR_W-1:0]        pc_inc;
  logic                     hs, hs_halt, hs_jump, hs_seq;
  logic                     direct_load;
  logic [OPC_W-1:0]         rom_opc;
  logic [INSTR_W-OPC_W-1:0] rom_opr;

  always_comb begin
    pc_inc  = pc + ADDR_W'(1);
    rom_opc = instr_in[INSTR_W-1 -: OPC_W];
    rom_opr = instr_in[INSTR_W-OPC_W-1:0];
    hs      = (state == PRESENT) && out_valid && out_ready;
    hs_halt = hs && (opcode == HALT_OPC);
    hs_jump = hs && !hs_halt && jump_req;
    hs_seq  = hs && !hs_halt && !jump_req;
  end

`ifdef IFU_PREFETCH_EN
  // word(pc+1) is on instr_in only once PRESENT has lasted at least one full cycle
  logic nxt_ok;

  always_ff @(posedge clk) begin
    if (rst) nxt_ok <= 1'b0;
    else     nxt_ok <= (state == PRESENT) && !hs;
  end

  assign direct_load = hs_seq && nxt_ok;
`else
  assign direct_load = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ISSUE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = PRESENT;
      PRESENT: begin
        if (hs_halt)          next_state = HALTED;
        else if (hs_jump)     next_state = ISSUE;
        else if (direct_load) next_state = PRESENT;
        else if (hs_seq)
`ifdef IFU_PREFETCH_EN
          next_state = CAPTURE;
`else
          next_state = ISSUE;
`endif
      end
      HALTED:  next_state = HALTED;
    endcase
  end

  always_comb begin
    instr_addr = pc;
`ifdef IFU_PREFETCH_EN
    if (state == PRESENT) instr_addr = pc_inc;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= START_ADDR;
      out_valid <= 1'b0;
      opcode    <= '0;
      operand   <= '0;
      halted    <= 1'b0;
    end else begin
      if (state == CAPTURE) begin
        opcode    <= rom_opc;
        operand   <= rom_opr;
        out_valid <= 1'b1;
      end
      if (hs_halt) begin
        out_valid <= 1'b0;
        halted    <= 1'b1;
      end else if (hs_jump) begin
        pc        <= jump_target;
        out_valid <= 1'b0;
      end else if (hs_seq) begin
        pc <= pc_inc;
        if (direct_load) begin
          opcode  <= rom_opc;
          operand <= rom_opr;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural ROM plus a transaction-level
// PC model (next pc = jump target or pc+1 mod 256 on each accepted instruction).
module tb_instr_fetch_unit;

  localparam logic [7:0] START = 8'd0;
  localparam logic [7:0] HALT  = 8'd255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  instr_addr;
  logic [25:0] instr_in;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  opcode;
  logic [17:0] operand;
  logic [7:0]  pc;
  logic        jump_req = 1'b0;
  logic [7:0]  jump_target = 8'd0;
  logic        halted;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [25:0] rom [256];

  instr_fetch_unit #(
    .ADDR_W(8), .INSTR_W(26), .OPC_W(8), .START_ADDR(8'd0), .HALT_OPC(8'd255)
  ) dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .operand(operand),
    .pc(pc), .jump_req(jump_req), .jump_target(jump_target), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_in <= rom[instr_addr];

  function automatic logic [7:0] w_opc(input logic [7:0] a);
    logic [25:0] w;
    w = rom[a];
    return w[25:18];
  endfunction

  function automatic logic [17:0] w_opr(input logic [7:0] a);
    logic [25:0] w;
    w = rom[a];
    return w[17:0];
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = {8'($urandom_range(0, 254)), 18'($urandom)};
    rom[0] = {8'd2, 18'd0};
    rom[1] = {8'd4, 18'd20};
    rom[2] = {8'd3, 18'd0};
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle after reset, rst released).
  task automatic reset_dut();
    rst = 1'b1; out_ready = 1'b0; jump_req = 1'b0; jump_target = 8'd0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned budget, output bit ok);
    int unsigned n;
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic accept(input bit jmp, input logic [7:0] tgt);
    out_ready = 1'b1; jump_req = jmp; jump_target = tgt;
    @(negedge clk);
    out_ready = 1'b0; jump_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (pc !== START) begin failures++; $display("FAIL reset_pc: got %0d expected %0d", pc, START); end
    checks++; if (instr_addr !== START) begin failures++; $display("FAIL reset_addr: got %0d expected %0d", instr_addr, START); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (opcode !== 8'd0) begin failures++; $display("FAIL reset_opcode: got %0d expected 0", opcode); end
    checks++; if (operand !== 18'd0) begin failures++; $display("FAIL reset_operand: got %0d expected 0", operand); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_basic_timing();
    logic        exp_v;
    int unsigned seen;
    logic [7:0]  exp_opc [3];
    exp_opc[0] = 8'd2; exp_opc[1] = 8'd4; exp_opc[2] = 8'd3;
    reset_dut();
    out_ready = 1'b1;
    seen = 0;
    checks++; if (instr_addr !== START) begin failures++; $display("FAIL addr_cycle0: got %0d expected %0d", instr_addr, START); end
    for (int c = 0; c < 10; c++) begin
`ifdef IFU_PREFETCH_EN
      exp_v = (c >= 2) && (c % 2 == 0);
`else
      exp_v = (c >= 2) && ((c - 2) % 3 == 0);
`endif
      checks++;
      if (out_valid !== exp_v) begin failures++; $display("FAIL timing_valid_c%0d: got %b expected %b", c, out_valid, exp_v); end
      if (exp_v && seen < 3) begin
        checks++;
        if (opcode !== exp_opc[seen] || pc !== 8'(seen)) begin
          failures++; $display("FAIL timing_payload_%0d: opcode=%0d pc=%0d expected opcode=%0d pc=%0d", seen, opcode, pc, exp_opc[seen], seen);
        end
        if (seen == 1) begin
          checks++; if (operand !== 18'd20) begin failures++; $display("FAIL timing_operand: got %0d expected 20", operand); end
        end
      end
      if (exp_v) seen++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random_traffic(input int unsigned ncyc);
    logic [7:0]  exp_pc;
    int unsigned gap, accepted;
    bit          pend;
    reset_dut();
    exp_pc = START; gap = 0; accepted = 0; pend = 0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      checks++;
      if (out_valid === 1'b1) begin
        gap = 0;
        if (pc !== exp_pc || opcode !== w_opc(exp_pc) || operand !== w_opr(exp_pc)) begin
          failures++; $display("FAIL rand_present_c%0d: pc=%0d opcode=%0d operand=%0d expected pc=%0d opcode=%0d operand=%0d",
                               c, pc, opcode, operand, exp_pc, w_opc(exp_pc), w_opr(exp_pc));
        end
      end else begin
        gap++;
        if (pend || gap > 2) begin
          failures++; $display("FAIL rand_valid_c%0d: out_valid=%b gap=%0d held=%0d expected valid", c, out_valid, gap, pend);
        end
      end
      out_ready   = ($urandom_range(0, 2) != 0);
      jump_req    = ($urandom_range(0, 3) == 0);
      jump_target = 8'($urandom);
      pend = (out_valid === 1'b1) && !out_ready;
      if (out_valid === 1'b1 && out_ready) begin
        accepted++;
        exp_pc = jump_req ? jump_target : exp_pc + 8'd1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0; jump_req = 1'b0;
    checks++;
    if (accepted < ncyc / 8) begin failures++; $display("FAIL rand_throughput: accepted=%0d expected at least %0d", accepted, ncyc / 8); end
  endtask

  task automatic test_stall();
    bit ok;
    reset_dut();
    wait_valid(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_first_valid: out_valid=%b expected 1", out_valid); end
    out_ready = 1'b0; jump_req = 1'b1; jump_target = 8'd20;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || pc !== 8'd0 || opcode !== w_opc(8'd0) || operand !== w_opr(8'd0)) begin
        failures++; $display("FAIL stall_hold_%0d: valid=%b pc=%0d opcode=%0d expected valid=1 pc=0 opcode=%0d", k, out_valid, pc, opcode, w_opc(8'd0));
      end
    end
    accept(1'b0, 8'd20);
    wait_valid(4, ok);
    checks++;
    if (!ok || pc !== 8'd1 || opcode !== w_opc(8'd1) || operand !== w_opr(8'd1)) begin
      failures++; $display("FAIL stall_next: valid=%b pc=%0d opcode=%0d expected valid=1 pc=1 opcode=%0d", out_valid, pc, opcode, w_opc(8'd1));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || pc !== 8'd1) begin
        failures++; $display("FAIL stall_single_consume_%0d: valid=%b pc=%0d expected valid=1 pc=1", k, out_valid, pc);
      end
    end
  endtask

  task automatic test_jump();
    bit ok;
    reset_dut();
    wait_valid(5, ok);
    accept(1'b1, 8'd52);
    wait_valid(4, ok);
    checks++;
    if (!ok || pc !== 8'd52 || opcode !== w_opc(8'd52)) begin
      failures++; $display("FAIL jump_to_52: valid=%b pc=%0d opcode=%0d expected valid=1 pc=52 opcode=%0d", out_valid, pc, opcode, w_opc(8'd52));
    end
    @(negedge clk); @(negedge clk);
    accept(1'b1, 8'd20);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (out_valid !== (k == 3)) begin
        failures++; $display("FAIL jump_latency_%0d: out_valid=%b pc=%0d expected valid=%0d", k, out_valid, pc, (k == 3));
      end
      if (k < 3) @(negedge clk);
    end
    checks++;
    if (pc !== 8'd20 || opcode !== w_opc(8'd20) || operand !== w_opr(8'd20)) begin
      failures++; $display("FAIL jump_target_word: pc=%0d opcode=%0d operand=%0d expected pc=20 opcode=%0d operand=%0d",
                           pc, opcode, operand, w_opc(8'd20), w_opr(8'd20));
    end
  endtask

  task automatic test_halt();
    bit ok;
    rom[183] = {HALT, 18'($urandom)};
    reset_dut();
    wait_valid(5, ok);
    accept(1'b1, 8'd183);
    wait_valid(4, ok);
    checks++;
    if (!ok || pc !== 8'd183 || opcode !== HALT) begin
      failures++; $display("FAIL halt_present: valid=%b pc=%0d opcode=%0d expected valid=1 pc=183 opcode=255", out_valid, pc, opcode);
    end
    accept(1'b1, 8'd7);
    checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL halt_enter: halted=%b valid=%b expected halted=1 valid=0", halted, out_valid);
    end
    for (int k = 0; k < 12; k++) begin
      out_ready = 1'($urandom); jump_req = 1'($urandom); jump_target = 8'($urandom);
      @(negedge clk);
      checks++;
      if (instr_addr !== 8'd183 || pc !== 8'd183 || halted !== 1'b1 || out_valid !== 1'b0) begin
        failures++; $display("FAIL halt_frozen_%0d: addr=%0d pc=%0d halted=%b valid=%b expected addr=183 pc=183 halted=1 valid=0",
                             k, instr_addr, pc, halted, out_valid);
      end
    end
    out_ready = 1'b0; jump_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pc !== START || halted !== 1'b0 || instr_addr !== START) begin
      failures++; $display("FAIL halt_reset: pc=%0d halted=%b addr=%0d expected pc=0 halted=0 addr=0", pc, halted, instr_addr);
    end
    wait_valid(4, ok);
    checks++;
    if (!ok || pc !== START) begin failures++; $display("FAIL halt_restart: valid=%b pc=%0d expected valid=1 pc=0", out_valid, pc); end
    rom[183] = {8'd17, 18'($urandom)};
  endtask

  task automatic test_wrap_and_midreset();
    bit ok;
    reset_dut();
    wait_valid(5, ok);
    accept(1'b1, 8'd255);
    wait_valid(4, ok);
    checks++;
    if (!ok || pc !== 8'd255) begin failures++; $display("FAIL wrap_at_255: valid=%b pc=%0d expected valid=1 pc=255", out_valid, pc); end
    accept(1'b0, 8'd0);
    wait_valid(4, ok);
    checks++;
    if (!ok || pc !== 8'd0 || opcode !== w_opc(8'd0)) begin
      failures++; $display("FAIL wrap_to_0: valid=%b pc=%0d opcode=%0d expected valid=1 pc=0 opcode=%0d", out_valid, pc, opcode, w_opc(8'd0));
    end
    accept(1'b0, 8'd0);
    wait_valid(4, ok);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || pc !== START || halted !== 1'b0) begin
      failures++; $display("FAIL midreset_clear: valid=%b pc=%0d halted=%b expected valid=0 pc=0 halted=0", out_valid, pc, halted);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_c1: out_valid=%b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || pc !== START || opcode !== w_opc(START)) begin
      failures++; $display("FAIL midreset_restart: valid=%b pc=%0d opcode=%0d expected valid=1 pc=0 opcode=%0d", out_valid, pc, opcode, w_opc(START));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fill_rom();
    test_reset();
    test_basic_timing();
    test_stall();
    test_jump();
    test_halt();
    test_wrap_and_midreset();
    test_random_traffic(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
